// File: rtl/mem_channel_arbiter_if.sv
// Consumer-side LSU buses plus memory-side channel buses around the channel arbiter.
// master is the arbiter's view; slave is the view of the LSUs and the memory they share.
interface mem_channel_arbiter_if #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 4
);
   logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
   logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
   logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
   logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
   logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
   logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

   logic [NUM_CHANNELS-1:0]            mem_read_valid;
   logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
   logic [NUM_CHANNELS-1:0]            mem_read_ready;
   logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;
   logic [NUM_CHANNELS-1:0]            mem_write_valid;
   logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address;
   logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data;
   logic [NUM_CHANNELS-1:0]            mem_write_ready;

   modport master (
      input  consumer_read_valid, consumer_read_address,
      output consumer_read_ready, consumer_read_data,
      input  consumer_write_valid, consumer_write_address, consumer_write_data,
      output consumer_write_ready,
      output mem_read_valid, mem_read_address,
      input  mem_read_ready, mem_read_data,
      output mem_write_valid, mem_write_address, mem_write_data,
      input  mem_write_ready
   );

   modport slave (
      output consumer_read_valid, consumer_read_address,
      input  consumer_read_ready, consumer_read_data,
      output consumer_write_valid, consumer_write_address, consumer_write_data,
      input  consumer_write_ready,
      input  mem_read_valid, mem_read_address,
      output mem_read_ready, mem_read_data,
      input  mem_write_valid, mem_write_address, mem_write_data,
      output mem_write_ready
   );
endinterface

// File: rtl/mem_channel_arbiter.sv
// Round-robin sharing of NUM_CHANNELS memory channels among NUM_CONSUMERS LSU requesters.
// Each channel runs its own grant / wait / release handshake; all outputs are registered.
module mem_channel_arbiter #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 4,
   parameter int WRITE_ENABLE  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_channel_arbiter_if.master bus
);
   localparam int ID_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELEASE} state_e;

   state_e                             state_q [NUM_CHANNELS];
   logic [ID_W-1:0]                    id_q    [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]            is_rd_q;
   logic [NUM_CONSUMERS-1:0]           busy_q;
   logic [ID_W-1:0]                    rr_ptr_q, rr_ptr_d;

   logic [NUM_CHANNELS-1:0]            mrv_q, mwv_q;
   logic [NUM_CHANNELS*ADDR_BITS-1:0]  mra_q, mwa_q;
   logic [NUM_CHANNELS*DATA_BITS-1:0]  mwd_q;
   logic [NUM_CONSUMERS-1:0]           crr_q, cwr_q;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] crd_q;

   logic [NUM_CONSUMERS-1:0]           wr_vld, taken_d;
   logic [NUM_CHANNELS-1:0]            gnt_vld_d, gnt_rd_d;
   logic [ID_W-1:0]                    gnt_id_d [NUM_CHANNELS];
   logic [ID_W-1:0]                    cand_d;

   // base and off are both below NUM_CONSUMERS, so one subtraction wraps.
   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_CONSUMERS) sum = sum - NUM_CONSUMERS;
      return sum[ID_W-1:0];
   endfunction

   assign wr_vld = (WRITE_ENABLE != 0) ? bus.consumer_write_valid : '0;

   // Lower channels claim first; a consumer taken by one channel is hidden from the next.
   always_comb begin
      taken_d  = '0;
      rr_ptr_d = rr_ptr_q;
      cand_d   = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         gnt_vld_d[ch] = 1'b0;
         gnt_rd_d[ch]  = 1'b0;
         gnt_id_d[ch]  = '0;
         if (state_q[ch] == IDLE) begin
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
               cand_d = wrap_idx(rr_ptr_q, i);
               if (!gnt_vld_d[ch] && !busy_q[cand_d] && !taken_d[cand_d] &&
                   (bus.consumer_read_valid[cand_d] || wr_vld[cand_d])) begin
                  gnt_vld_d[ch] = 1'b1;
                  gnt_id_d[ch]  = cand_d;
                  gnt_rd_d[ch]  = bus.consumer_read_valid[cand_d];
               end
            end
            if (gnt_vld_d[ch]) begin
               taken_d[gnt_id_d[ch]] = 1'b1;
               rr_ptr_d              = wrap_idx(gnt_id_d[ch], 1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_q[ch] <= IDLE;
            id_q[ch]    <= '0;
         end
         is_rd_q  <= '0;
         busy_q   <= '0;
         rr_ptr_q <= '0;
         mrv_q    <= '0;
         mra_q    <= '0;
         mwv_q    <= '0;
         mwa_q    <= '0;
         mwd_q    <= '0;
         crr_q    <= '0;
         crd_q    <= '0;
         cwr_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
               IDLE: begin
                  if (gnt_vld_d[ch]) begin
                     id_q[ch]               <= gnt_id_d[ch];
                     is_rd_q[ch]            <= gnt_rd_d[ch];
                     busy_q[gnt_id_d[ch]]   <= 1'b1;
                     if (gnt_rd_d[ch]) begin
                        mrv_q[ch]                          <= 1'b1;
                        mra_q[ch*ADDR_BITS +: ADDR_BITS]   <=
                           bus.consumer_read_address[gnt_id_d[ch]*ADDR_BITS +: ADDR_BITS];
                        state_q[ch]                        <= READ_WAIT;
                     end else begin
                        mwv_q[ch]                          <= 1'b1;
                        mwa_q[ch*ADDR_BITS +: ADDR_BITS]   <=
                           bus.consumer_write_address[gnt_id_d[ch]*ADDR_BITS +: ADDR_BITS];
                        mwd_q[ch*DATA_BITS +: DATA_BITS]   <=
                           bus.consumer_write_data[gnt_id_d[ch]*DATA_BITS +: DATA_BITS];
                        state_q[ch]                        <= WRITE_WAIT;
                     end
                  end
               end
               READ_WAIT: begin
                  if (bus.mem_read_ready[ch]) begin
                     mrv_q[ch]                                <= 1'b0;
                     crr_q[id_q[ch]]                          <= 1'b1;
                     crd_q[id_q[ch]*DATA_BITS +: DATA_BITS]   <=
                        bus.mem_read_data[ch*DATA_BITS +: DATA_BITS];
                     state_q[ch]                              <= RELEASE;
                  end
               end
               WRITE_WAIT: begin
                  if (bus.mem_write_ready[ch]) begin
                     mwv_q[ch]       <= 1'b0;
                     cwr_q[id_q[ch]] <= 1'b1;
                     state_q[ch]     <= RELEASE;
                  end
               end
               RELEASE: begin
                  // Hold the ack until the consumer drops the valid it was served on.
                  if (is_rd_q[ch] ? !bus.consumer_read_valid[id_q[ch]] : !wr_vld[id_q[ch]]) begin
                     crr_q[id_q[ch]]  <= 1'b0;
                     cwr_q[id_q[ch]]  <= 1'b0;
                     busy_q[id_q[ch]] <= 1'b0;
                     state_q[ch]      <= IDLE;
                  end
               end
               default: state_q[ch] <= IDLE;
            endcase
         end
      end
   end

   assign bus.mem_read_valid       = mrv_q;
   assign bus.mem_read_address     = mra_q;
   assign bus.consumer_read_ready  = crr_q;
   assign bus.consumer_read_data   = crd_q;
   assign bus.mem_write_valid      = (WRITE_ENABLE != 0) ? mwv_q : '0;
   assign bus.mem_write_address    = (WRITE_ENABLE != 0) ? mwa_q : '0;
   assign bus.mem_write_data       = (WRITE_ENABLE != 0) ? mwd_q : '0;
   assign bus.consumer_write_ready = (WRITE_ENABLE != 0) ? cwr_q : '0;
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench for mem_channel_arbiter: a vector table for single transactions plus
// hand-written sequences for reset, contention, fairness and the read-only build.
module tb_mem_channel_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   mem_channel_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4)) if0 ();
   mem_channel_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1)) if1 ();
   mem_channel_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4)) if2 ();

   mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4),
                         .WRITE_ENABLE(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
   mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1),
                         .WRITE_ENABLE(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
   mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4),
                         .WRITE_ENABLE(0)) u2 (.clk(clk), .reset(reset), .bus(if2));

   // Memory models: instant responder (data = address ^ A5) or manual control for u0.
   logic       auto0   = 1'b0;
   logic [3:0] man_mrr = '0;
   logic [3:0] man_mwr = '0;
   logic [7:0] man_mrd = '0;

   assign if0.mem_read_ready  = auto0 ? if0.mem_read_valid  : man_mrr;
   assign if0.mem_write_ready = auto0 ? if0.mem_write_valid : man_mwr;
   assign if0.mem_read_data   = auto0 ? (if0.mem_read_address ^ {4{8'hA5}}) : {24'h0, man_mrd};
   assign if1.mem_read_ready  = if1.mem_read_valid;
   assign if1.mem_write_ready = if1.mem_write_valid;
   assign if1.mem_read_data   = if1.mem_read_address ^ 8'hA5;
   assign if2.mem_read_ready  = if2.mem_read_valid;
   assign if2.mem_write_ready = if2.mem_write_valid;
   assign if2.mem_read_data   = if2.mem_read_address ^ {4{8'hA5}};

   typedef struct {
      logic [7:0] rv;
      logic [7:0] wv;
      logic [3:0] mrr;
      logic [3:0] mwr;
      logic [7:0] mrd;
      logic [3:0] e_mrv;
      logic [3:0] e_mwv;
      logic [7:0] e_crr;
      logic [7:0] e_cwr;
      logic [7:0] e_a0;
      logic [7:0] e_wd0;
      int         k;
      logic [7:0] e_crd;
   } vec_t;

   vec_t tbl [15];
   int   served [8];
   int   order [4];
   int   n;

   function automatic vec_t mk(input logic [7:0] rv, input logic [7:0] wv,
                               input logic [3:0] mrr, input logic [3:0] mwr, input logic [7:0] mrd,
                               input logic [3:0] e_mrv, input logic [3:0] e_mwv,
                               input logic [7:0] e_crr, input logic [7:0] e_cwr,
                               input logic [7:0] e_a0, input logic [7:0] e_wd0,
                               input int k, input logic [7:0] e_crd);
      vec_t v;
      v.rv = rv; v.wv = wv; v.mrr = mrr; v.mwr = mwr; v.mrd = mrd;
      v.e_mrv = e_mrv; v.e_mwv = e_mwv; v.e_crr = e_crr; v.e_cwr = e_cwr;
      v.e_a0 = e_a0; v.e_wd0 = e_wd0; v.k = k; v.e_crd = e_crd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_u0_zero(input string tag);
      chk({tag, " mem_read_valid"}, if0.mem_read_valid, 0);
      chk({tag, " mem_read_address"}, if0.mem_read_address, 0);
      chk({tag, " mem_write_valid"}, if0.mem_write_valid, 0);
      chk({tag, " mem_write_address"}, if0.mem_write_address, 0);
      chk({tag, " mem_write_data"}, if0.mem_write_data, 0);
      chk({tag, " consumer_read_ready"}, if0.consumer_read_ready, 0);
      chk({tag, " consumer_read_data"}, if0.consumer_read_data, 0);
      chk({tag, " consumer_write_ready"}, if0.consumer_write_ready, 0);
      chk({tag, " rr_ptr"}, 64'(u0.rr_ptr_q), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Consumer k: read addr 0E+k, write addr 7F+k, write data 3B+k.
      if0.consumer_read_valid = '0; if0.consumer_write_valid = '0;
      if1.consumer_read_valid = '0; if1.consumer_write_valid = '0;
      if2.consumer_read_valid = '0; if2.consumer_write_valid = '0;
      for (int k = 0; k < 8; k++) begin
         if0.consumer_read_address[k*8 +: 8]  = 8'(8'h0E + k);
         if0.consumer_write_address[k*8 +: 8] = 8'(8'h7F + k);
         if0.consumer_write_data[k*8 +: 8]    = 8'(8'h3B + k);
         if1.consumer_read_address[k*8 +: 8]  = 8'(8'h0E + k);
         if1.consumer_write_address[k*8 +: 8] = 8'(8'h7F + k);
         if1.consumer_write_data[k*8 +: 8]    = 8'(8'h3B + k);
         if2.consumer_read_address[k*8 +: 8]  = 8'(8'h0E + k);
         if2.consumer_write_address[k*8 +: 8] = 8'(8'h7F + k);
         if2.consumer_write_data[k*8 +: 8]    = 8'(8'h3B + k);
      end

      //            rv     wv     mrr   mwr   mrd    mrv   mwv   crr    cwr    a0     wd0   k  crd
      tbl[0]  = mk(8'h04, 8'h00, 4'h0, 4'h0, 8'h00, 4'h1, 4'h0, 8'h00, 8'h00, 8'h10, 8'h00, 2, 8'h00);
      tbl[1]  = mk(8'h04, 8'h00, 4'h0, 4'h0, 8'h00, 4'h1, 4'h0, 8'h00, 8'h00, 8'h10, 8'h00, 2, 8'h00);
      tbl[2]  = mk(8'h04, 8'h00, 4'h1, 4'h0, 8'hAB, 4'h0, 4'h0, 8'h04, 8'h00, 8'h00, 8'h00, 2, 8'hAB);
      tbl[3]  = mk(8'h04, 8'h00, 4'h0, 4'h0, 8'h00, 4'h0, 4'h0, 8'h04, 8'h00, 8'h00, 8'h00, 2, 8'hAB);
      tbl[4]  = mk(8'h00, 8'h00, 4'h0, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'hAB);
      tbl[5]  = mk(8'h00, 8'h00, 4'h0, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'hAB);
      tbl[6]  = mk(8'h00, 8'h02, 4'h0, 4'h0, 8'h00, 4'h0, 4'h1, 8'h00, 8'h00, 8'h80, 8'h3C, 2, 8'hAB);
      tbl[7]  = mk(8'h00, 8'h02, 4'h0, 4'h1, 8'h00, 4'h0, 4'h0, 8'h00, 8'h02, 8'h00, 8'h00, 2, 8'hAB);
      tbl[8]  = mk(8'h00, 8'h00, 4'h0, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'hAB);
      tbl[9]  = mk(8'h08, 8'h08, 4'h0, 4'h0, 8'h00, 4'h1, 4'h0, 8'h00, 8'h00, 8'h11, 8'h00, 3, 8'h00);
      tbl[10] = mk(8'h08, 8'h08, 4'h1, 4'h0, 8'h77, 4'h0, 4'h0, 8'h08, 8'h00, 8'h00, 8'h00, 3, 8'h77);
      tbl[11] = mk(8'h00, 8'h08, 4'h0, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 3, 8'h77);
      tbl[12] = mk(8'h00, 8'h08, 4'h0, 4'h0, 8'h00, 4'h0, 4'h1, 8'h00, 8'h00, 8'h82, 8'h3E, 3, 8'h77);
      tbl[13] = mk(8'h00, 8'h08, 4'h0, 4'h1, 8'h00, 4'h0, 4'h0, 8'h00, 8'h08, 8'h00, 8'h00, 3, 8'h77);
      tbl[14] = mk(8'h00, 8'h00, 4'h0, 4'h0, 8'h00, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 3, 8'h77);

      tick();
      tick();
      chk_u0_zero("reset");
      chk("reset u1 mem_read_valid", if1.mem_read_valid, 0);
      reset = 1'b0;

      for (int r = 0; r < 15; r++) begin
         if0.consumer_read_valid  = tbl[r].rv;
         if0.consumer_write_valid = tbl[r].wv;
         man_mrr = tbl[r].mrr;
         man_mwr = tbl[r].mwr;
         man_mrd = tbl[r].mrd;
         tick();
         chk($sformatf("vec%0d mem_read_valid", r), if0.mem_read_valid, tbl[r].e_mrv);
         chk($sformatf("vec%0d mem_write_valid", r), if0.mem_write_valid, tbl[r].e_mwv);
         chk($sformatf("vec%0d consumer_read_ready", r), if0.consumer_read_ready, tbl[r].e_crr);
         chk($sformatf("vec%0d consumer_write_ready", r), if0.consumer_write_ready, tbl[r].e_cwr);
         chk($sformatf("vec%0d consumer_read_data[%0d]", r, tbl[r].k),
             if0.consumer_read_data[tbl[r].k*8 +: 8], tbl[r].e_crd);
         if (tbl[r].e_mrv[0])
            chk($sformatf("vec%0d mem_read_address[0]", r), if0.mem_read_address[7:0], tbl[r].e_a0);
         if (tbl[r].e_mwv[0]) begin
            chk($sformatf("vec%0d mem_write_address[0]", r), if0.mem_write_address[7:0], tbl[r].e_a0);
            chk($sformatf("vec%0d mem_write_data[0]", r), if0.mem_write_data[7:0], tbl[r].e_wd0);
         end
      end
      man_mrr = '0; man_mwr = '0; man_mrd = '0;

      // Reset while channel 0 waits on a withheld memory response.
      if0.consumer_read_valid = 8'h04;
      tick();
      chk("midrst grant", if0.mem_read_valid, 4'h1);
      tick();
      chk("midrst still waiting", if0.mem_read_valid, 4'h1);
      reset = 1'b1;
      if0.consumer_read_valid = 8'h00;
      tick();
      chk_u0_zero("midrst");
      reset = 1'b0;
      if0.consumer_read_valid = 8'h20;
      tick();
      chk("postrst mem_read_valid", if0.mem_read_valid, 4'h1);
      chk("postrst mem_read_address", if0.mem_read_address[7:0], 8'h13);
      man_mrr = 4'h1; man_mrd = 8'h5E;
      tick();
      chk("postrst consumer_read_ready", if0.consumer_read_ready, 8'h20);
      chk("postrst consumer_read_data", if0.consumer_read_data[5*8 +: 8], 8'h5E);
      man_mrr = '0; man_mrd = '0;
      if0.consumer_read_valid = 8'h00;
      tick();
      chk("postrst release", if0.consumer_read_ready, 8'h00);

      // Eight readers on four channels with an instant memory.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      auto0 = 1'b1;
      if0.consumer_read_valid = 8'hFF;
      tick();
      chk("wave1 mem_read_valid", if0.mem_read_valid, 4'hF);
      chk("wave1 addresses", if0.mem_read_address, 32'h11100F0E);
      chk("wave1 rr_ptr", 64'(u0.rr_ptr_q), 4);
      for (int k = 0; k < 8; k++) served[k] = -1;
      for (int cyc = 2; cyc <= 20; cyc++) begin
         tick();
         for (int k = 0; k < 8; k++) begin
            if (if0.consumer_read_ready[k] && served[k] < 0) begin
               served[k] = cyc;
               chk($sformatf("contention data c%0d", k), if0.consumer_read_data[k*8 +: 8],
                   8'(8'h0E + k) ^ 8'hA5);
               if0.consumer_read_valid[k] = 1'b0;
            end
         end
      end
      for (int k = 0; k < 8; k++)
         chk($sformatf("contention serve cycle c%0d", k), served[k], (k < 4) ? 2 : 5);
      chk("wave2 rr_ptr", 64'(u0.rr_ptr_q), 0);
      auto0 = 1'b0;

      // Single channel, consumers 0 and 5 re-request as soon as they are released.
      for (int i = 0; i < 4; i++) order[i] = -1;
      n = 0;
      if1.consumer_read_valid = 8'h21;
      for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
         tick();
         for (int k = 0; k < 8; k += 5) begin
            if (if1.consumer_read_ready[k] && if1.consumer_read_valid[k]) begin
               if (n < 4) order[n] = k;
               n++;
               if1.consumer_read_valid[k] = 1'b0;
            end else if (!if1.consumer_read_ready[k] && !if1.consumer_read_valid[k]) begin
               if1.consumer_read_valid[k] = 1'b1;
            end
         end
      end
      if1.consumer_read_valid = 8'h00;
      chk("fairness grant count", n, 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("fairness order[%0d]", i), order[i], (i % 2 == 0) ? 0 : 5);

      // Read-only build: writes are ignored, reads still served.
      if2.consumer_write_valid = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("we0 mem_write_valid", if2.mem_write_valid, 0);
         chk("we0 consumer_write_ready", if2.consumer_write_ready, 0);
         chk("we0 no read grant", if2.mem_read_valid, 0);
      end
      if2.consumer_read_valid = 8'h40;
      tick();
      chk("we0 read grant", if2.mem_read_valid, 4'h1);
      chk("we0 read address", if2.mem_read_address[7:0], 8'h14);
      tick();
      chk("we0 read ready", if2.consumer_read_ready, 8'h40);
      chk("we0 read data", if2.consumer_read_data[6*8 +: 8], 8'hB1);
      if2.consumer_read_valid = 8'h00;
      tick();
      chk("we0 release", if2.consumer_read_ready, 8'h00);
      chk("we0 mem_write_valid end", if2.mem_write_valid, 0);
      chk("we0 mem_write_address", if2.mem_write_address, 0);
      chk("we0 mem_write_data", if2.mem_write_data, 0);
      chk("we0 consumer_write_ready end", if2.consumer_write_ready, 0);
      if2.consumer_write_valid = 8'h00;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
